div_seq_ctrl: RTL

Multi-cycle unsigned restoring-division sequencer built around the shared (N+1)-bit two's-complement subtractor NBitSub (a + ~b + c_in, c_in tied 1). The block latches one dividend/divisor pair and steps the subtractor once per clock for N iterations. It accumulates quotient and remainder in internal registers and signals completion with a one-cycle pulse. It sits beside NBitALU as the long-latency divide resource for the lab datapath.

---
 rtl/div_seq_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/div_seq_ctrl.sv
// ---------------------------------------------------------------------------
// div_seq_ctrl -- multi-cycle unsigned restoring divider.
//
// One dividend/divisor pair is latched on an accepted start. The block then
// steps a shared (N+1)-bit subtractor (NBitSub) once per clock for N
// iterations. Results are registered on the edge that enters DONE, and
// o_done pulses for one cycle.
//
// Optional feature macro: DIV_ZERO_DETECT_EN
//   defined   : a zero divisor finishes in one cycle and raises o_div_by_zero.
//   undefined : a zero divisor runs the full sequence, and o_div_by_zero is
//               tied 0.
//
// Ports
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous active-low reset
//   i_start        division request, sampled only in IDLE
//   i_dividend[N]  unsigned dividend, sampled with i_start
//   i_divisor[N]   unsigned divisor, sampled with i_start
//   o_busy         high whenever the sequencer is not IDLE
//   o_done         one-cycle completion pulse; results are valid in this cycle
//   o_quotient[N]  registered quotient, held until the next completion
//   o_remainder[N] registered remainder, held until the next completion
//   o_div_by_zero  registered divide-by-zero flag
// ---------------------------------------------------------------------------

// (W)-bit two's-complement subtractor: a + ~b + 1. A carry-out of 1 means no
// borrow, i.e. a >= b.
module NBitSub #(
    parameter int W = 9
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_diff,
    output logic         o_cout
);
    assign {o_cout, o_diff} = {1'b0, i_a} + {1'b0, ~i_b} + {{W{1'b0}}, 1'b1};
endmodule

module div_seq_ctrl #(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_quotient,
    output logic [N-1:0] o_remainder,
    output logic         o_div_by_zero
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         r_state, w_state_nxt;
    logic [N-1:0]   r_q, r_d, r_quo, r_rem;
    logic [N:0]     r_r;
    logic [CW-1:0]  r_cnt;

    logic [N:0]     w_s, w_diff, w_r_nxt;
    logic [N-1:0]   w_q_nxt;
    logic           w_cout, w_last, w_zero;

    // The partial remainder shifts left and takes in the next dividend bit.
    // R[N] is always 0 after an update, so the bit shifted out carries no
    // information.
    assign w_s = (r_r << 1) | {{N{1'b0}}, r_q[N-1]};

    NBitSub #(.W(N+1)) u_sub (
        .i_a    (w_s),
        .i_b    ({1'b0, r_d}),
        .o_diff (w_diff),
        .o_cout (w_cout)
    );

    // Restoring step: keep the difference only when no borrow occurred.
    assign w_r_nxt = w_cout ? w_diff : w_s;
    assign w_q_nxt = {r_q[N-2:0], w_cout};
    assign w_last  = (r_cnt == CW'(N-1));
    assign w_zero  = (i_divisor == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
`ifdef DIV_ZERO_DETECT_EN
                    w_state_nxt = w_zero ? S_DONE : S_RUN;
`else
                    w_state_nxt = S_RUN;
`endif
                end
            end
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef DIV_ZERO_DETECT_EN
    logic r_dbz;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q   <= '0;
            r_d   <= '0;
            r_r   <= '0;
            r_cnt <= '0;
            r_quo <= '0;
            r_rem <= '0;
`ifdef DIV_ZERO_DETECT_EN
            r_dbz <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_q   <= i_dividend;
                        r_d   <= i_divisor;
                        r_r   <= '0;
                        r_cnt <= '0;
`ifdef DIV_ZERO_DETECT_EN
                        // Short-circuit: publish the results directly on
                        // the edge that enters DONE.
                        if (w_zero) begin
                            r_quo <= '1;
                            r_rem <= i_dividend;
                            r_dbz <= 1'b1;
                        end
`endif
                    end
                end
                S_RUN: begin
                    r_r   <= w_r_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    // Publish on the last iteration so the results are
                    // visible in the DONE cycle.
                    if (w_last) begin
                        r_quo <= w_q_nxt;
                        r_rem <= N'(w_r_nxt);
`ifdef DIV_ZERO_DETECT_EN
                        r_dbz <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;
`ifdef DIV_ZERO_DETECT_EN
    assign o_div_by_zero = r_dbz;
`else
    assign o_div_by_zero = 1'b0;
`endif
endmodule
